// File: rtl/trap_pkg.sv
// ============================================================================
// Module      : trap_pkg
// Description : Shared constants, cause codes and FSM state for trap_ctrl_m.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] EXC_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;

  localparam int unsigned IRQ_MSI       = 3;
  localparam int unsigned IRQ_MTI       = 7;
  localparam int unsigned IRQ_MEI       = 11;
  localparam int unsigned IRQ_PLAT_BASE = 16;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } trap_state_e;

  // Bits of mip/mie that exist for a given number of platform lines.
  function automatic logic [63:0] irq_impl_mask(input int unsigned n_plat);
    logic [63:0] m;
    m = '0;
    m[IRQ_MSI] = 1'b1;
    m[IRQ_MTI] = 1'b1;
    m[IRQ_MEI] = 1'b1;
    for (int unsigned i = 0; i < n_plat; i++) begin
      m[IRQ_PLAT_BASE + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
// Module      : irq_sync
// Description : Per-line flop-chain synchroniser, asynchronous reset to 0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_sync = i_async;
    end else begin : g_chain
      logic [WIDTH-1:0] r_chain [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < STAGES; k++) begin
            r_chain[k] <= '0;
          end
        end else begin
          r_chain[0] <= i_async;
          for (int k = 1; k < STAGES; k++) begin
            r_chain[k] <= r_chain[k-1];
          end
        end
      end

      assign o_sync = r_chain[STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/trap_ctrl_m.sv
// ============================================================================
// Module      : trap_ctrl_m
// Description : Machine-mode trap controller with prioritised interrupts.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module trap_ctrl_m
  import trap_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              NUM_PLAT_IRQ = 4,
  parameter int              SYNC_STAGES  = 2,
  parameter logic [XLEN-1:0] RESET_MTVEC  = 32'h0000_0100
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    boundary,
  input  logic [XLEN-1:0]         pc,
  input  logic                    exc_valid,
  input  logic [3:0]              exc_cause,
  input  logic [XLEN-1:0]         exc_tval,
  input  logic                    mret,
  input  logic                    sw_irq,
  input  logic                    timer_irq,
  input  logic                    ext_irq,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
  input  logic                    csr_we,
  input  logic [11:0]             csr_addr,
  input  logic [XLEN-1:0]         csr_wdata,
  output logic [XLEN-1:0]         csr_rdata,
  output logic                    trap_req,
  output logic [XLEN-1:0]         trap_vector,
  input  logic                    trap_ack,
  output logic [XLEN-1:0]         mret_pc
);

  localparam logic [63:0]     MIE_MASK64 = irq_impl_mask(NUM_PLAT_IRQ);
  localparam logic [XLEN-1:0] MIE_MASK   = MIE_MASK64[XLEN-1:0];

  trap_state_e       r_state;
  logic              r_mstatus_mie;
  logic              r_mstatus_mpie;
  logic [XLEN-1:0]   r_mie;
  logic [XLEN-1:0]   r_mtvec;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mtval;
  logic              r_trap_req;
  logic [XLEN-1:0]   r_trap_vector;

  logic [NUM_PLAT_IRQ-1:0] w_plat_sync;
  logic [XLEN-1:0]   w_mip;
  logic [XLEN-1:0]   w_pend;
  logic              w_irq_eligible;
  logic [4:0]        w_irq_code;
  logic              w_capture;
  logic [XLEN-1:0]   w_cause;
  logic [XLEN-1:0]   w_base;
  logic [XLEN-1:0]   w_vector;
  logic              w_wr_mstatus;
  logic              w_wr_mie;
  logic              w_wr_mtvec;
  logic              w_wr_mepc;
  logic              w_wr_mcause;
  logic              w_wr_mtval;

  irq_sync #(
    .WIDTH  (NUM_PLAT_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_plat_sync (
    .clk     (clk),
    .rst_n   (resetn),
    .i_async (plat_irq),
    .o_sync  (w_plat_sync)
  );

  always_comb begin
    w_mip          = '0;
    w_mip[IRQ_MSI] = sw_irq;
    w_mip[IRQ_MTI] = timer_irq;
    w_mip[IRQ_MEI] = ext_irq;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
      w_mip[IRQ_PLAT_BASE + i] = w_plat_sync[i];
    end
  end

  assign w_pend         = w_mip & r_mie;
  assign w_irq_eligible = r_mstatus_mie & (|w_pend) & boundary & ~exc_valid;

  // Later assignments override earlier ones, so the highest priority is last.
  always_comb begin
    w_irq_code = '0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (w_pend[IRQ_PLAT_BASE + i]) w_irq_code = 5'(IRQ_PLAT_BASE + i);
    end
    if (w_pend[IRQ_MTI]) w_irq_code = 5'(IRQ_MTI);
    if (w_pend[IRQ_MSI]) w_irq_code = 5'(IRQ_MSI);
    if (w_pend[IRQ_MEI]) w_irq_code = 5'(IRQ_MEI);
  end

  assign w_capture = (r_state == ST_IDLE) & (exc_valid | w_irq_eligible);

  always_comb begin
    w_cause = '0;
    if (exc_valid) begin
      w_cause[3:0] = exc_cause;
    end else begin
      w_cause[XLEN-1] = 1'b1;
      w_cause[4:0]    = w_irq_code;
    end
  end

  assign w_base   = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_vector = (r_mtvec[1:0] == 2'b01 && !exc_valid)
                  ? w_base + XLEN'({w_irq_code, 2'b00})
                  : w_base;

  assign w_wr_mstatus = csr_we & (csr_addr == CSR_MSTATUS);
  assign w_wr_mie     = csr_we & (csr_addr == CSR_MIE);
  assign w_wr_mtvec   = csr_we & (csr_addr == CSR_MTVEC);
  assign w_wr_mepc    = csr_we & (csr_addr == CSR_MEPC);
  assign w_wr_mcause  = csr_we & (csr_addr == CSR_MCAUSE);
  assign w_wr_mtval   = csr_we & (csr_addr == CSR_MTVAL);

  // CSR writes land first; mret and capture below override the fields they own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= RESET_MTVEC;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_trap_req     <= 1'b0;
      r_trap_vector  <= {RESET_MTVEC[XLEN-1:2], 2'b00};
    end else begin
      if (w_wr_mstatus) begin
        r_mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
        r_mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
      end
      if (w_wr_mie)    r_mie    <= csr_wdata & MIE_MASK;
      if (w_wr_mtvec)  r_mtvec  <= csr_wdata;
      if (w_wr_mepc)   r_mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
      if (w_wr_mcause) r_mcause <= csr_wdata;
      if (w_wr_mtval)  r_mtval  <= csr_wdata;

      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state        <= ST_PEND;
            r_mepc         <= pc;
            r_mcause       <= w_cause;
            r_mtval        <= exc_valid ? exc_tval : '0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_trap_req     <= 1'b1;
            r_trap_vector  <= w_vector;
          end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
          end
        end
        ST_PEND: begin
          if (trap_ack) begin
            r_state    <= ST_IDLE;
            r_trap_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_trap_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = r_mstatus_mie;
        csr_rdata[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
      end
      CSR_MIE:    csr_rdata = r_mie;
      CSR_MTVEC:  csr_rdata = r_mtvec;
      CSR_MEPC:   csr_rdata = r_mepc;
      CSR_MCAUSE: csr_rdata = r_mcause;
      CSR_MTVAL:  csr_rdata = r_mtval;
      CSR_MIP:    csr_rdata = w_mip;
      default:    csr_rdata = '0;
    endcase
  end

  assign trap_req    = r_trap_req;
  assign trap_vector = r_trap_vector;
  assign mret_pc     = r_mepc;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl_m.sv
// ============================================================================
// Module      : tb_trap_ctrl_m
// Description : Self-checking bench for trap_ctrl_m against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl_m;

  localparam int NPLAT = 4;
  localparam int SYNC  = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              boundary;
  logic [31:0]       pc;
  logic              exc_valid;
  logic [3:0]        exc_cause;
  logic [31:0]       exc_tval;
  logic              mret;
  logic              sw_irq, timer_irq, ext_irq;
  logic [NPLAT-1:0]  plat_irq;
  logic              csr_we;
  logic [11:0]       csr_addr;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  logic              trap_req;
  logic [31:0]       trap_vector;
  logic              trap_ack;
  logic [31:0]       mret_pc;

  trap_ctrl_m #(
    .XLEN(32), .NUM_PLAT_IRQ(NPLAT), .SYNC_STAGES(SYNC), .RESET_MTVEC(32'h100)
  ) dut (
    .clk(clk), .resetn(resetn), .boundary(boundary), .pc(pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .mret(mret), .sw_irq(sw_irq), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .plat_irq(plat_irq), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap_req(trap_req),
    .trap_vector(trap_vector), .trap_ack(trap_ack), .mret_pc(mret_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural state of the reference model.
  bit          m_gie, m_mpie, m_pend;
  logic [31:0] m_ien, m_mtvec, m_mepc, m_mcause, m_mtval, m_vec;
  logic [NPLAT-1:0] m_hist[$];
  int          prio[$];
  logic [31:0] ien_mask;

  function automatic void model_reset();
    m_gie = 0; m_mpie = 0; m_pend = 0;
    m_ien = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_vec = 32'h100;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
  endfunction

  function automatic logic [31:0] model_mip();
    logic [31:0] v = 0;
    v[3] = sw_irq; v[7] = timer_irq; v[11] = ext_irq;
    for (int i = 0; i < NPLAT; i++) v[16+i] = m_hist[$][i];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_gie) << 3);
      12'h304: return m_ien;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return model_mip();
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: the inputs currently driven are the ones sampled.
  function automatic void model_step();
    logic [31:0] p = model_mip() & m_ien;
    bit old_gie = m_gie, old_mpie = m_mpie;
    logic [31:0] old_tvec = m_mtvec;
    bit elig = m_gie && (p != 0) && boundary && !exc_valid;
    bit cap  = !m_pend && (exc_valid || elig);
    int code = 0;
    bit found = 0;
    foreach (prio[k]) if (!found && p[prio[k]]) begin code = prio[k]; found = 1; end
    if (csr_we) begin
      case (csr_addr)
        12'h300: begin m_gie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
        12'h304: m_ien = csr_wdata & ien_mask;
        12'h305: m_mtvec = csr_wdata;
        12'h341: m_mepc = csr_wdata & ~32'h3;
        12'h342: m_mcause = csr_wdata;
        12'h343: m_mtval = csr_wdata;
        default: ;
      endcase
    end
    if (cap) begin
      m_mepc   = pc;
      m_mcause = exc_valid ? {28'h0, exc_cause} : (32'h8000_0000 | code);
      m_mtval  = exc_valid ? exc_tval : 32'h0;
      m_mpie   = old_gie;
      m_gie    = 0;
      m_pend   = 1;
      m_vec    = (old_tvec[1:0] == 2'd1 && !exc_valid) ? (old_tvec & ~32'h3) + 4 * code
                                                       : (old_tvec & ~32'h3);
    end else if (!m_pend && mret) begin
      m_gie  = old_mpie;
      m_mpie = 1;
    end else if (m_pend && trap_ack) begin
      m_pend = 0;
    end
    m_hist.push_front(plat_irq);
    void'(m_hist.pop_back());
  endfunction

  task automatic step();
    #1 chk("csr_rdata", csr_rdata, model_read(csr_addr));
    @(posedge clk);
    model_step();
    #1;
    chk("trap_req", 32'(trap_req), 32'(m_pend));
    if (m_pend) chk("trap_vector", trap_vector, m_vec);
    chk("mret_pc", mret_pc, m_mepc);
    @(negedge clk);
  endtask

  task automatic quiet();
    boundary = 0; exc_valid = 0; exc_cause = 0; exc_tval = 0; mret = 0;
    sw_irq = 0; timer_irq = 0; ext_irq = 0; plat_irq = 0;
    csr_we = 0; csr_addr = 12'h300; csr_wdata = 0; trap_ack = 0; pc = 0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1 chk(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 0;
  endtask

  task automatic ack();
    trap_ack = 1; step(); trap_ack = 0;
  endtask

  logic [11:0] addr_tab[9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'h7C0, 12'h300};

  initial begin
    prio = {11, 3, 7};
    for (int i = 0; i < NPLAT; i++) prio.push_back(16 + i);
    ien_mask = 32'h888 | (((32'h1 << NPLAT) - 1) << 16);
    quiet();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;

    // Reset state
    rd("rst_mtvec", 12'h305, 32'h100);
    rd("rst_mstatus", 12'h300, 0);
    rd("rst_mie", 12'h304, 0);
    rd("rst_mepc", 12'h341, 0);
    rd("rst_mcause", 12'h342, 0);
    rd("rst_mtval", 12'h343, 0);
    chk("rst_trap_req", 32'(trap_req), 0);

    // Exception capture
    wr(12'h300, 32'h8);
    exc_valid = 1; exc_cause = 4; exc_tval = 32'h1002; pc = 32'h200;
    step();
    quiet();
    chk("exc_req", 32'(trap_req), 1);
    chk("exc_vec", trap_vector, 32'h100);
    rd("exc_mepc", 12'h341, 32'h200);
    rd("exc_mcause", 12'h342, 32'h4);
    rd("exc_mtval", 12'h343, 32'h1002);
    rd("exc_mstatus", 12'h300, 32'h80);
    ack();
    chk("exc_ack_req", 32'(trap_req), 0);

    // Vectored interrupt, MEI beats MTI
    wr(12'h305, 32'h101);
    wr(12'h304, 32'h880);
    wr(12'h300, 32'h8);
    timer_irq = 1; ext_irq = 1; boundary = 1; pc = 32'h300;
    step();
    quiet();
    chk("vec_req", 32'(trap_req), 1);
    chk("vec_vector", trap_vector, 32'h12C);
    rd("vec_mcause", 12'h342, 32'h8000_000B);
    rd("vec_mepc", 12'h341, 32'h300);
    ack();
    mret = 1; step(); mret = 0;
    rd("mret_mstatus", 12'h300, 32'h88);
    chk("mret_pc_val", mret_pc, 32'h300);

    // Platform line through the synchroniser
    wr(12'h305, 32'h100);
    wr(12'h304, 32'h4_0000);
    plat_irq = 4'b0100;
    step();
    rd("plat_mip_1", 12'h344, 0);
    step();
    rd("plat_mip_2", 12'h344, 32'h4_0000);
    boundary = 1; pc = 32'h400;
    step();
    boundary = 0;
    chk("plat_req", 32'(trap_req), 1);
    rd("plat_mcause", 12'h342, 32'h8000_0012);
    ack();
    boundary = 1;
    step();
    chk("plat_mie0_no_trap", 32'(trap_req), 0);
    quiet();

    // Exception beats pending timer; exception beats mret
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    timer_irq = 1; boundary = 1; exc_valid = 1; exc_cause = 2;
    step();
    quiet();
    rd("sim_exc_cause", 12'h342, 32'h2);
    ack();
    wr(12'h300, 32'h8);
    exc_valid = 1; exc_cause = 11; mret = 1;
    step();
    quiet();
    chk("sim_mret_req", 32'(trap_req), 1);
    rd("sim_mret_mstatus", 12'h300, 32'h80);
    ack();

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      boundary  = 1'($urandom_range(0, 1));
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_cause = 4'($urandom);
      exc_tval  = $urandom;
      pc        = $urandom;
      mret      = ($urandom_range(0, 9) == 0);
      sw_irq    = ($urandom_range(0, 3) == 0);
      timer_irq = ($urandom_range(0, 3) == 0);
      ext_irq   = ($urandom_range(0, 3) == 0);
      plat_irq  = NPLAT'($urandom & $urandom);
      trap_ack  = ($urandom_range(0, 2) == 0);
      csr_we    = ($urandom_range(0, 5) == 0);
      csr_addr  = addr_tab[$urandom_range(0, 8)];
      csr_wdata = $urandom;
      if (csr_addr == 12'h300 && $urandom_range(0, 1) == 1) csr_wdata[3] = 1'b1;
      step();
    end
    quiet();
    repeat (4) ack();

    // Asynchronous reset with the trap left unacknowledged
    exc_valid = 1; exc_cause = 6; pc = 32'h500;
    step();
    quiet();
    chk("arst_pre_req", 32'(trap_req), 1);
    #2 resetn = 0;
    #1 chk("arst_req_low", 32'(trap_req), 0);
    model_reset();
    rd("arst_mtvec", 12'h305, 32'h100);
    rd("arst_mcause", 12'h342, 0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1;
    step();
    chk("arst_idle_req", 32'(trap_req), 0);
    exc_valid = 1; exc_cause = 6; pc = 32'h600;
    step();
    quiet();
    chk("arst_recapture", 32'(trap_req), 1);
    rd("arst_recap_cause", 12'h342, 32'h6);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trap_ctrl_m.md
Name: trap_ctrl_m

Overview:
Parametrised machine-mode trap controller that generalises the single-timer interrupt logic to a priority-arbitrated set of sources: synchronous exceptions, MSI, MTI, MEI and NUM_PLAT_IRQ platform lines. It owns the mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause and mtval state. It raises a held trap request with a target vector to the core fetch stage and restores state on mret.

Parameters:
XLEN, 32, datapath/CSR width
NUM_PLAT_IRQ, 4, platform interrupt lines mapped to mip/mie bits 16..16+N-1 (1..16)
SYNC_STAGES, 2, synchroniser depth for asynchronous irq inputs (0 = bypass)
RESET_MTVEC, 32'h0000_0100, mtvec reset value

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
boundary  in  1  core at instruction boundary; interrupts may be taken
pc  in  XLEN  PC of current instruction (faulting PC, or next PC at boundary)
exc_valid  in  1  synchronous exception this cycle
exc_cause  in  4  exception code (0 fetch-misaligned, 2 illegal, 4 load-misaligned, 6 store-misaligned, 11 ecall)
exc_tval  in  XLEN  bad address or instruction for mtval
mret  in  1  mret executing
sw_irq, timer_irq, ext_irq  in  1 each  MSIP/MTIP/MEIP level inputs
plat_irq  in  NUM_PLAT_IRQ  platform levels, asynchronous
csr_we  in  1  CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  combinational read of csr_addr (0 for unowned addresses)
trap_req  out  1  trap request to core
trap_vector  out  XLEN  target PC, valid while trap_req
trap_ack  in  1  core has redirected fetch
mret_pc  out  XLEN  mepc, used as mret target

Behaviour:
- Reset: mstatus.MIE=0, MPIE=0, mie=0, mepc=0, mcause=0, mtval=0, mtvec=RESET_MTVEC, trap_req=0, FSM=IDLE. trap_vector=RESET_MTVEC masked to base. csr_rdata tracks the reset CSRs.
- mip is read-only: bit3=sw_irq, bit7=timer_irq, bit11=ext_irq, bits 16+i = synchronised plat_irq[i]. Level-sensitive with no latching. A source deasserted before capture is lost.
- Pending set P = mip & mie. An interrupt is eligible when MIE=1, P≠0, boundary=1 and exc_valid=0.
- Priority: exception > MEI(11) > MSI(3) > MTI(7) > plat lowest index first.
- FSM IDLE -> PEND on capture (exception, or eligible interrupt). In the capture cycle, registered at the clock edge:
  - mepc=pc
  - mcause = {0,exc_cause} for exceptions, or {1,code} for interrupts
  - mtval = exc_tval for exceptions, 0 for interrupts
  - MPIE=MIE, MIE=0, trap_req=1
- trap_vector = {mtvec[XLEN-1:2],2'b00}. If mtvec[1:0]==1 and the trap is an interrupt, it is base+4*code. Values 2 and 3 in mtvec[1:0] act as direct mode.
- PEND: trap_req held and stable until trap_ack. Then go to IDLE with trap_req=0 on the next edge. New exceptions and interrupts are ignored in PEND. An mret in PEND is ignored.
- Latency: capture edge -> trap_req high 1 cycle after the event. Interrupt source edge -> mip visible after SYNC_STAGES cycles.
- mret in IDLE: MIE=MPIE, MPIE=1. mret_pc is always mepc.
- Simultaneous events:
  - exc_valid with mret: the exception wins and mret is dropped.
  - Capture with csr_we to mstatus/mepc/mcause/mtval: capture wins for those fields.
  - csr_we to mie/mtvec in the same cycle still applies.
  - mret with csr_we mstatus: mret wins for MIE/MPIE.
- CSR writes, one cycle after csr_we: mstatus (0x300) only bits 3 and 7 writable. mie (0x304) writable only at implemented bits. mtvec (0x305) bits [XLEN-1:2] plus the mode bits. mepc (0x341) bits[1:0] forced 0. mcause (0x342) and mtval (0x343) fully writable. mip (0x344) writes ignored.
- Reset asserted mid-PEND: trap_req drops immediately (asynchronous) and all state returns to reset values.
- The interrupt code set is fixed. Exception codes are passed through unchecked.

Decomposition:
- Shared package trap_pkg holds:
  - CSR address constants (MSTATUS, MIE, MTVEC, MEPC, MCAUSE, MTVAL, MIP)
  - cause codes (EXC_*, IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11, IRQ_PLAT_BASE=16)
  - mstatus bit indices
  - FSM state enum {IDLE, PEND}
- One sub-module, irq_sync: a parametrised SYNC_STAGES flop chain per line with asynchronous active-low reset to 0, instantiated for plat_irq.
- Priority encode stays inline.

Test Plan:
- Reset, then read all CSRs -> mtvec=0x100, others 0, trap_req=0.
- Exception: exc_valid=1, cause=4, tval=0x1002, pc=0x200 -> next cycle trap_req=1, mepc=0x200, mcause=4, mtval=0x1002, MIE 1->0, MPIE=1, vector=0x100. Ack -> trap_req=0.
- Vectored interrupt: mtvec=0x101, mie=0x880, MIE=1, timer_irq and ext_irq both high at boundary, pc=0x300 -> mcause=0x8000000B, vector=0x12C, mepc=0x300. mret -> MIE=1, mret_pc=0x300.
- Platform irq: plat_irq[2] high, mie bit18=1 -> mip bit18 set after 2 cycles. Capture yields mcause=0x80000012. With MIE=0 there is no trap.
- Simultaneous: exc_valid with timer pending and boundary -> mcause=exception code. exc_valid with mret -> mret ignored and MPIE keeps the trap-saved value.
- Asynchronous reset during PEND with ack withheld -> trap_req low before the next edge, and the FSM restarts in IDLE.
